// File: rtl/dct2d_chen_seq.sv
// 8x8 2-D DCT sequencer around a shared external 1-D 8-point DCT.
// Row passes are forwarded straight from the input, results land in an
// 8x8 transpose buffer, column passes are issued from that buffer, and the
// finished coefficient rows are drained with a valid/ready handshake.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | waiting for the first spatial row of a block
//  S_ROWS  | forwarding input rows to the 1-D DCT, storing row results
//  S_COLS  | issuing buffer columns to the 1-D DCT, storing column results
//  S_DRAIN | presenting coefficient rows to the consumer
module dct2d_chen_seq #(
   parameter int DATA_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0][DATA_W-1:0] in_row,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0][DATA_W-1:0] out_row,
   output logic                   dct_valid_in,
   output logic [7:0][DATA_W-1:0] dct_x,
   input  logic                   dct_valid_out,
   input  logic [7:0][DATA_W-1:0] dct_y,
   output logic                   busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROWS  = 2'd1,
      S_COLS  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [3:0]               r_iss_cnt;
   logic [3:0]               w_iss_nxt;
   logic [3:0]               r_ret_cnt;
   logic [3:0]               w_ret_nxt;
   logic [DATA_W-1:0]        r_buf [0:7][0:7];
   logic [7:0][DATA_W-1:0]   r_x_hold;
   logic [7:0][DATA_W-1:0]   w_col_rd;
   logic                     w_accept;
   logic                     w_ret_ok;
   logic                     w_row_wr;
   logic                     w_col_wr;

   // Input acceptance: only from IDLE or while row issues remain; never in reset.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         if (r_state == S_IDLE)
            in_ready = 1'b1;
         else if (r_state == S_ROWS && r_iss_cnt < 4'd8)
            in_ready = 1'b1;
      end
   end

   assign w_accept = in_valid & in_ready;

   // A 1-D result is only meaningful while a pass is collecting results;
   // pulses in IDLE/DRAIN or after all 8 returns (e.g. left over from an
   // abandoned block) are dropped here.
   assign w_ret_ok = dct_valid_out && (r_ret_cnt < 4'd8) &&
                     ((r_state == S_ROWS) || (r_state == S_COLS));
   assign w_row_wr = w_ret_ok && (r_state == S_ROWS);
   assign w_col_wr = w_ret_ok && (r_state == S_COLS);

   // Column currently being issued, read straight out of the buffer.
   always_comb begin
      for (int r = 0; r < 8; r++)
         w_col_rd[r] = r_buf[r][r_iss_cnt[2:0]];
   end

   // Coefficient row currently offered to the consumer.
   always_comb begin
      for (int v = 0; v < 8; v++)
         out_row[v] = r_buf[r_ret_cnt[2:0]][v];
   end

   assign busy = (r_state != S_IDLE);

   // Next-state, counter and handshake logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_iss_nxt    = r_iss_cnt;
      w_ret_nxt    = r_ret_cnt;
      dct_valid_in = 1'b0;
      dct_x        = r_x_hold;
      out_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               dct_valid_in = 1'b1;
               dct_x        = in_row;
               w_state_nxt  = S_ROWS;
               w_iss_nxt    = 4'd1;
            end
         end
         S_ROWS: begin
            if (w_accept) begin
               dct_valid_in = 1'b1;
               dct_x        = in_row;
               w_iss_nxt    = r_iss_cnt + 4'd1;
            end
            if (w_ret_ok) begin
               w_ret_nxt = r_ret_cnt + 4'd1;
               if (r_ret_cnt == 4'd7) begin
                  w_state_nxt = S_COLS;
                  w_iss_nxt   = 4'd0;
                  w_ret_nxt   = 4'd0;
               end
            end
         end
         S_COLS: begin
            if (r_iss_cnt < 4'd8) begin
               dct_valid_in = 1'b1;
               dct_x        = w_col_rd;
               w_iss_nxt    = r_iss_cnt + 4'd1;
            end
            if (w_ret_ok) begin
               w_ret_nxt = r_ret_cnt + 4'd1;
               if (r_ret_cnt == 4'd7) begin
                  w_state_nxt = S_DRAIN;
                  w_iss_nxt   = 4'd0;
                  w_ret_nxt   = 4'd0;
               end
            end
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_ret_nxt = r_ret_cnt + 4'd1;
               if (r_ret_cnt == 4'd7) begin
                  w_state_nxt = S_IDLE;
                  w_ret_nxt   = 4'd0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_iss_nxt   = 4'd0;
            w_ret_nxt   = 4'd0;
         end
      endcase
   end

   // State, counters and the last issued vector (dct_x holds between issues).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_iss_cnt <= 4'd0;
         r_ret_cnt <= 4'd0;
         r_x_hold  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_iss_cnt <= w_iss_nxt;
         r_ret_cnt <= w_ret_nxt;
         if (dct_valid_in)
            r_x_hold <= dct_x;
      end
   end

   // Transpose buffer: row results fill a row, column results fill a column.
   // A column write lands on a column already issued, so it never disturbs
   // the column being read in the same cycle. Contents are not reset.
   always_ff @(posedge clk) begin
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (w_row_wr && (r_ret_cnt[2:0] == 3'(r)))
               r_buf[r][c] <= dct_y[c];
            else if (w_col_wr && (r_ret_cnt[2:0] == 3'(c)))
               r_buf[r][c] <= dct_y[r];
         end
      end
   end

endmodule

// File: tb/tb_dct2d_chen_seq.sv
// Directed bench for dct2d_chen_seq with an identity 1-D DCT stub of
// selectable latency. Inputs change on the falling edge; outputs are
// sampled 1 time unit later.
module tb_dct2d_chen_seq;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [7:0][15:0]    in_row;
   logic                out_valid;
   logic                out_ready;
   logic [7:0][15:0]    out_row;
   logic                dct_valid_in;
   logic [7:0][15:0]    dct_x;
   logic                dct_valid_out;
   logic [7:0][15:0]    dct_y;
   logic                busy;

   always #5 clk = ~clk;

   dct2d_chen_seq #(.DATA_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_row        (in_row),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_row       (out_row),
      .dct_valid_in  (dct_valid_in),
      .dct_x         (dct_x),
      .dct_valid_out (dct_valid_out),
      .dct_y         (dct_y),
      .busy          (busy)
   );

   // Identity 1-D DCT stub: fixed latency lat (1..8), not reset, never stalls.
   int               lat = 3;
   logic [7:0]       stub_v = '0;
   logic [7:0][15:0] stub_d [8];

   always @(posedge clk) begin
      stub_v    <= {stub_v[6:0], dct_valid_in};
      stub_d[0] <= dct_x;
      for (int i = 1; i < 8; i++)
         stub_d[i] <= stub_d[i-1];
   end

   always_comb begin
      dct_valid_out = stub_v[3'(lat - 1)];
      dct_y         = stub_d[3'(lat - 1)];
   end

   int               vec  = 0;
   int               errs = 0;
   int               cyc  = 0;
   int               acc_cnt, first_acc_cyc, first_ov_cyc, out_cnt, iss_total, mirror_err, bp_n;
   logic             s_acc;
   logic             blk_timeout;
   logic [7:0][15:0] out_mem [16];
   logic [7:0][15:0] bp_rows [8];

   function automatic logic [7:0][15:0] mk_row(input int base, input int k);
      logic [7:0][15:0] r;
      for (int c = 0; c < 8; c++)
         r[c] = 16'(base + 16 * k + c);
      return r;
   endfunction

   task automatic clear_log();
      acc_cnt = 0; first_acc_cyc = -1; first_ov_cyc = -1; out_cnt = 0;
      iss_total = 0; mirror_err = 0; bp_n = 0;
   endtask

   // One clock cycle: called right after a falling edge with inputs set,
   // logs what the DUT does this cycle, returns at the next falling edge.
   task automatic step();
      int acc_before;
      #1;
      cyc++;
      acc_before = acc_cnt;
      s_acc = in_valid && in_ready;
      if (s_acc) begin
         if (acc_cnt == 0) first_acc_cyc = cyc;
         acc_cnt++;
      end
      if (dct_valid_in === 1'b1) iss_total++;
      if (acc_before < 8) begin
         if (dct_valid_in !== s_acc) mirror_err++;
         else if (s_acc && (dct_x !== in_row)) mirror_err++;
      end
      if (out_valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (out_valid === 1'b1 && !out_ready && bp_n < 8) begin
         bp_rows[bp_n] = out_row;
         bp_n++;
      end
      if (out_valid === 1'b1 && out_ready) begin
         if (out_cnt < 16) out_mem[out_cnt] = out_row;
         out_cnt++;
      end
      @(negedge clk);
   endtask

   // Feeds one block of rows base+16*k+c and drains it; gap=1 offers a row
   // only every other cycle; out_ready drops for bp_len cycles at drain row bp_row.
   task automatic run_block(input int base, input int gap, input int bp_row,
                            input int bp_len, input logic hold_valid);
      int   k = 0;
      int   t = 0;
      logic done = 1'b0;
      clear_log();
      while (!done && t < 400) begin
         if (k < 8) begin
            in_valid = (gap == 0) ? 1'b1 : (t % 2 == 0);
            in_row   = mk_row(base, k);
         end else begin
            in_valid = hold_valid && (out_cnt < 8);
            in_row   = mk_row(base, 9);
         end
         out_ready = !((out_cnt == bp_row) && (bp_n < bp_len));
         step();
         if (s_acc && k < 8) k++;
         t++;
         done = (out_cnt >= 8) && (busy === 1'b0);
      end
      blk_timeout = !done;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_row = '0;
      step();
      step();
      vec++;
      if (in_ready !== 1'b0) begin
         errs++; $display("FAIL reset_in_ready_during: got %b expected 0", in_ready);
      end
      rst = 1'b0;
      #1;
      vec++;
      if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vec++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      vec++;
      if (dct_valid_in !== 1'b0) begin errs++; $display("FAIL reset_dct_valid_in: got %b expected 0", dct_valid_in); end
      vec++;
      if (dct_x !== '0) begin errs++; $display("FAIL reset_dct_x: got %h expected 0", dct_x); end
      vec++;
      if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      lat = 3;
      run_block(0, 0, -1, 0, 1'b0);
      vec++;
      if (blk_timeout || out_cnt != 8) begin
         errs++; $display("FAIL basic_rows_out: got %0d expected 8 (timeout=%b)", out_cnt, blk_timeout);
      end
      for (int u = 0; u < 8; u++) begin
         vec++;
         if (out_mem[u] !== mk_row(0, u)) begin
            errs++; $display("FAIL basic_row%0d: got %h expected %h", u, out_mem[u], mk_row(0, u));
         end
      end
      vec++;
      if (first_ov_cyc - first_acc_cyc != 22) begin
         errs++; $display("FAIL basic_latency: got %0d expected 22", first_ov_cyc - first_acc_cyc);
      end
      vec++;
      if (iss_total != 16) begin errs++; $display("FAIL basic_issues: got %0d expected 16", iss_total); end
      vec++;
      if (mirror_err != 0) begin errs++; $display("FAIL basic_forward: got %0d errors expected 0", mirror_err); end
   endtask

   task automatic test_latency();
      int lats [2] = '{1, 8};
      for (int i = 0; i < 2; i++) begin
         lat = lats[i];
         for (int j = 0; j < 3; j++) step();
         run_block(0, 0, -1, 0, 1'b0);
         vec++;
         if (blk_timeout || out_cnt != 8) begin
            errs++; $display("FAIL lat%0d_rows_out: got %0d expected 8", lat, out_cnt);
         end
         for (int u = 0; u < 8; u++) begin
            vec++;
            if (out_mem[u] !== mk_row(0, u)) begin
               errs++; $display("FAIL lat%0d_row%0d: got %h expected %h", lat, u, out_mem[u], mk_row(0, u));
            end
         end
         vec++;
         if (first_ov_cyc - first_acc_cyc != 16 + 2 * lat) begin
            errs++; $display("FAIL lat%0d_latency: got %0d expected %0d", lat, first_ov_cyc - first_acc_cyc, 16 + 2 * lat);
         end
         vec++;
         if (iss_total != 16) begin errs++; $display("FAIL lat%0d_issues: got %0d expected 16", lat, iss_total); end
      end
      lat = 3;
      for (int j = 0; j < 3; j++) step();
   endtask

   task automatic test_gaps();
      run_block(16'h8000, 1, -1, 0, 1'b0);
      vec++;
      if (mirror_err != 0) begin errs++; $display("FAIL gaps_forward: got %0d errors expected 0", mirror_err); end
      vec++;
      if (acc_cnt != 8) begin errs++; $display("FAIL gaps_accepts: got %0d expected 8", acc_cnt); end
      for (int u = 0; u < 8; u++) begin
         vec++;
         if (out_mem[u] !== mk_row(16'h8000, u)) begin
            errs++; $display("FAIL gaps_row%0d: got %h expected %h", u, out_mem[u], mk_row(16'h8000, u));
         end
      end
   endtask

   task automatic test_backpressure();
      run_block(0, 0, 2, 5, 1'b0);
      vec++;
      if (bp_n != 5) begin errs++; $display("FAIL bp_stall_cycles: got %0d expected 5", bp_n); end
      for (int i = 0; i < 5; i++) begin
         vec++;
         if (bp_rows[i] !== mk_row(0, 2)) begin
            errs++; $display("FAIL bp_hold%0d: got %h expected %h", i, bp_rows[i], mk_row(0, 2));
         end
      end
      vec++;
      if (out_cnt != 8) begin errs++; $display("FAIL bp_rows_out: got %0d expected 8", out_cnt); end
      for (int u = 0; u < 8; u++) begin
         vec++;
         if (out_mem[u] !== mk_row(0, u)) begin
            errs++; $display("FAIL bp_row%0d: got %h expected %h", u, out_mem[u], mk_row(0, u));
         end
      end
   endtask

   task automatic test_in_ready_block();
      run_block(16'h0100, 0, -1, 0, 1'b1);
      vec++;
      if (acc_cnt != 8) begin errs++; $display("FAIL hold_accepts: got %0d expected 8", acc_cnt); end
      for (int u = 0; u < 8; u++) begin
         vec++;
         if (out_mem[u] !== mk_row(16'h0100, u)) begin
            errs++; $display("FAIL hold_row%0d: got %h expected %h", u, out_mem[u], mk_row(16'h0100, u));
         end
      end
      #1;
      vec++;
      if (in_ready !== 1'b1) begin errs++; $display("FAIL hold_idle_ready: got %b expected 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int t = 0;
      lat = 3;
      clear_log();
      while (iss_total < 11 && t < 60) begin
         in_valid = (acc_cnt < 8);
         in_row   = mk_row(16'h4000, acc_cnt);
         step();
         t++;
      end
      in_valid = 1'b0;
      vec++;
      if (iss_total < 11) begin errs++; $display("FAIL rstmid_reach_cols: got %0d issues expected 11", iss_total); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      vec++;
      if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      vec++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
      vec++;
      if (dct_valid_in !== 1'b0) begin errs++; $display("FAIL rstmid_dct_valid_in: got %b expected 0", dct_valid_in); end
      @(negedge clk);
      for (int j = 0; j < 6; j++) step();
      vec++;
      if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_stray_busy: got %b expected 0", busy); end
      run_block(16'h7F00, 0, -1, 0, 1'b0);
      vec++;
      if (blk_timeout || out_cnt != 8) begin
         errs++; $display("FAIL rstmid_rows_out: got %0d expected 8", out_cnt);
      end
      for (int u = 0; u < 8; u++) begin
         vec++;
         if (out_mem[u] !== mk_row(16'h7F00, u)) begin
            errs++; $display("FAIL rstmid_row%0d: got %h expected %h", u, out_mem[u], mk_row(16'h7F00, u));
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_row = '0;
      clear_log();
      @(negedge clk);
      test_reset();
      test_basic();
      test_latency();
      test_gaps();
      test_backpressure();
      test_in_ready_block();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish within 500000 time units");
      $fatal(1);
   end

endmodule
